l1_cache_controller: RTL

- Write-back, write-allocate, 2-way set-associative L1 data cache with internal tag, valid, dirty, LRU and data arrays.
- Serves the CPU's 16-bit word requests.
- Its downstream port drives the victim cache's l1_read/l1_write/mem_resp handshake.
- Every valid line it evicts is pushed downstream (exclusive victim cache), then the missing line is fetched.

---
 rtl/l1_cache_controller_pkg.sv | 42 ++++
 rtl/l1_cache_controller_array.sv | 68 ++++++
 rtl/l1_cache_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/l1_cache_controller_pkg.sv
// Shared geometry, state encoding and address-field helpers for the 2-way L1 data cache.
package l1_cache_types;
    localparam int L1_NUM_SETS   = 8;
    localparam int L1_LINE_BYTES = 16;
    localparam int L1_ADDR_W     = 16;

    localparam int IDX_W  = $clog2(L1_NUM_SETS);
    localparam int OFF_W  = $clog2(L1_LINE_BYTES);
    localparam int TAG_W  = L1_ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = OFF_W - 1;
    localparam int LINE_W = 8 * L1_LINE_BYTES;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        EVICT  = 2'd2,
        FETCH  = 2'd3
    } state_t;

    typedef logic [L1_ADDR_W-1:0] addr_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [IDX_W-1:0]     index_t;
    typedef logic [WSEL_W-1:0]    wsel_t;
    typedef logic [LINE_W-1:0]    line_t;

    function automatic tag_t addr_tag(input addr_t a);
        return a[L1_ADDR_W-1 -: TAG_W];
    endfunction

    function automatic index_t addr_index(input addr_t a);
        return a[OFF_W +: IDX_W];
    endfunction

    // Bit 0 is the byte-in-word position and is never used.
    function automatic wsel_t addr_wsel(input addr_t a);
        return a[1 +: WSEL_W];
    endfunction

    function automatic addr_t line_addr(input tag_t t, input index_t i);
        return {t, i, {OFF_W{1'b0}}};
    endfunction
endpackage

// File: rtl/l1_cache_controller_array.sv
// Two-way tag/valid/dirty/line storage: combinational read of both ways at one index,
// synchronous fill, byte-enable word write and invalidate on the selected way.
module l1_cache_array
    import l1_cache_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  index_t      idx_i,
    input  logic        way_i,
    input  logic        fill_i,
    input  logic        word_wr_i,
    input  logic        inval_i,
    input  tag_t        fill_tag_i,
    input  line_t       fill_line_i,
    input  wsel_t       wsel_i,
    input  logic [1:0]  be_i,
    input  logic [15:0] wdata_i,
    output tag_t  [1:0] tag_o,
    output line_t [1:0] line_o,
    output logic  [1:0] valid_o,
    output logic  [1:0] dirty_o
);
    tag_t  tag_mem  [2][L1_NUM_SETS];
    line_t line_mem [2][L1_NUM_SETS];
    logic [1:0][L1_NUM_SETS-1:0] valid_q;
    logic [1:0][L1_NUM_SETS-1:0] dirty_q;
    line_t merged_line;

    always_comb begin
        merged_line = line_mem[way_i][idx_i];
        if (be_i[0]) merged_line[{wsel_i, 4'b0000} +: 8] = wdata_i[7:0];
        if (be_i[1]) merged_line[{wsel_i, 4'b1000} +: 8] = wdata_i[15:8];
    end

    // Tags and data carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_mem[way_i][idx_i]  <= fill_tag_i;
            line_mem[way_i][idx_i] <= fill_line_i;
        end else if (word_wr_i) begin
            line_mem[way_i][idx_i] <= merged_line;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[way_i][idx_i] <= 1'b1;
            dirty_q[way_i][idx_i] <= 1'b0;
        end else if (word_wr_i) begin
            dirty_q[way_i][idx_i] <= 1'b1;
        end else if (inval_i) begin
            valid_q[way_i][idx_i] <= 1'b0;
            dirty_q[way_i][idx_i] <= 1'b0;
        end
    end

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            tag_o[w]   = tag_mem[w][idx_i];
            line_o[w]  = line_mem[w][idx_i];
            valid_o[w] = valid_q[w][idx_i];
            dirty_o[w] = dirty_q[w][idx_i];
        end
    end
endmodule

// File: rtl/l1_cache_controller.sv
// 2-way write-back/write-allocate L1 controller: IDLE latches a request, LOOKUP resolves it,
// EVICT pushes any valid victim downstream, FETCH refills the line and returns to LOOKUP.
module l1_cache_controller
    import l1_cache_types::*;
#(
    parameter int NUM_SETS   = L1_NUM_SETS,
    parameter int LINE_BYTES = L1_LINE_BYTES,
    parameter int ADDR_W     = L1_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [ADDR_W-1:0]       mem_address,
    input  logic [1:0]              mem_byte_enable,
    input  logic [15:0]             mem_wdata,
    output logic                    mem_resp,
    output logic [15:0]             mem_rdata,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [ADDR_W-1:0]       pmem_address,
    output logic [8*LINE_BYTES-1:0] pmem_wdata,
    output logic                    pmem_wdirty,
    input  logic [8*LINE_BYTES-1:0] pmem_rdata,
    input  logic                    pmem_resp
);
    state_t state_q, state_d;
    tag_t   tag_q;
    index_t idx_q;
    wsel_t  wsel_q;
    logic [1:0]  be_q;
    logic [15:0] wdata_q;
    logic        wr_q;
    logic        repl_q;
    logic [NUM_SETS-1:0] lru_q;

    tag_t  [1:0] way_tag;
    line_t [1:0] way_line;
    logic  [1:0] way_valid;
    logic  [1:0] way_dirty;
    logic  [1:0] hit_way;
    logic        hit;
    logic        hit_sel;
    logic        repl_way;
    line_t       hit_line;
    logic        arr_fill;
    logic        arr_word_wr;
    logic        arr_inval;
    logic        arr_way;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = mem_address[0];

    l1_cache_array u_array (
        .clk         (clk),
        .rst         (rst),
        .idx_i       (idx_q),
        .way_i       (arr_way),
        .fill_i      (arr_fill),
        .word_wr_i   (arr_word_wr),
        .inval_i     (arr_inval),
        .fill_tag_i  (tag_q),
        .fill_line_i (pmem_rdata),
        .wsel_i      (wsel_q),
        .be_i        (be_q),
        .wdata_i     (wdata_q),
        .tag_o       (way_tag),
        .line_o      (way_line),
        .valid_o     (way_valid),
        .dirty_o     (way_dirty)
    );

    // Replacement prefers an empty way (way 0 first), otherwise the LRU way.
    always_comb begin
        hit_way[0] = way_valid[0] && (way_tag[0] == tag_q);
        hit_way[1] = way_valid[1] && (way_tag[1] == tag_q);
        hit        = |hit_way;
        hit_sel    = hit_way[1];
        hit_line   = way_line[hit_sel];
        if (!way_valid[0])      repl_way = 1'b0;
        else if (!way_valid[1]) repl_way = 1'b1;
        else                    repl_way = lru_q[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_read || mem_write) state_d = LOOKUP;
            LOOKUP: begin
                if (hit)                      state_d = IDLE;
                else if (way_valid[repl_way]) state_d = EVICT;
                else                          state_d = FETCH;
            end
            EVICT:   if (pmem_resp) state_d = FETCH;
            FETCH:   if (pmem_resp) state_d = LOOKUP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= '0;
            idx_q   <= '0;
            wsel_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            repl_q  <= 1'b0;
            lru_q   <= '0;
        end else begin
            if (state_q == IDLE && (mem_read || mem_write)) begin
                tag_q   <= addr_tag(mem_address);
                idx_q   <= addr_index(mem_address);
                wsel_q  <= addr_wsel(mem_address);
                be_q    <= mem_byte_enable;
                wdata_q <= mem_wdata;
                wr_q    <= mem_write;
            end
            if (state_q == LOOKUP) begin
                if (hit) lru_q[idx_q] <= ~hit_sel;
                else     repl_q       <= repl_way;
            end
        end
    end

    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        pmem_wdirty  = 1'b0;
        arr_fill     = 1'b0;
        arr_word_wr  = 1'b0;
        arr_inval    = 1'b0;
        arr_way      = repl_q;
        case (state_q)
            LOOKUP: begin
                arr_way = hit_sel;
                if (hit) begin
                    mem_resp = 1'b1;
                    if (wr_q) arr_word_wr = 1'b1;
                    else      mem_rdata   = hit_line[{wsel_q, 4'b0000} +: 16];
                end
            end
            EVICT: begin
                pmem_write   = 1'b1;
                pmem_address = line_addr(way_tag[repl_q], idx_q);
                pmem_wdata   = way_line[repl_q];
                pmem_wdirty  = way_dirty[repl_q];
                arr_inval    = pmem_resp;
            end
            FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = line_addr(tag_q, idx_q);
                arr_fill     = pmem_resp;
            end
            default: ;
        endcase
    end
endmodule
